// File: rtl/csr_pkg.sv
// Shared types and default widths for the CSR row streamer.
// Widths track the p-bit engine defaults.
package csr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PTR,
        STREAM,
        DRAIN,
        DONE
    } csr_state_t;

    localparam int CSR_NUM_PBITS = 16;
    localparam int CSR_MAX_NNZ   = 256;
    localparam int CSR_VAL_WIDTH = 8;
    localparam int CSR_H_WIDTH   = 9;
    localparam int CSR_LEN_WIDTH = 5;

endpackage

// File: rtl/csr_row_streamer_if.sv
// Row request / beat stream bundle between the CSR streamer
// (slave) and the p-bit compute FSM (master).
interface csr_row_streamer_if
    import csr_pkg::*;
#(
    parameter int NUM_PBITS   = CSR_NUM_PBITS,
    parameter int VAL_WIDTH   = CSR_VAL_WIDTH,
    parameter int INDEX_WIDTH = $clog2(NUM_PBITS),
    parameter int H_WIDTH     = CSR_H_WIDTH,
    parameter int LEN_WIDTH   = CSR_LEN_WIDTH
);
    localparam int ROW_W = $clog2(NUM_PBITS + 1);

    logic                   start_load;
    logic [ROW_W-1:0]       current_row;
    logic                   compute_done;
    logic                   data_valid;
    logic [VAL_WIDTH-1:0]   value;
    logic [INDEX_WIDTH-1:0] index;
    logic [LEN_WIDTH-1:0]   row_length;
    logic [H_WIDTH-1:0]     h;
    logic                   load_done;
    logic                   cfg_err;

    modport slave (
        input  start_load, current_row, compute_done,
        output data_valid, value, index, row_length,
        output h, load_done, cfg_err
    );

    modport master (
        output start_load, current_row, compute_done,
        input  data_valid, value, index, row_length,
        input  h, load_done, cfg_err
    );

endinterface

// File: rtl/csr_rom.sv
// Single-port ROM, contents preloaded by the environment,
// with either a combinational or a 1-cycle registered read.
module csr_rom #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter     INIT_FILE = "",
  parameter bit SYNC      = 1'b1,
  parameter int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data
);
  logic [WIDTH-1:0] mem [DEPTH];

  if (SYNC) begin : g_sync
    logic [WIDTH-1:0] q;
    always_ff @(posedge clk) q <= mem[addr];
    assign data = q;
  end else begin : g_async
    logic unused_clk;
    assign unused_clk = clk;
    assign data = mem[addr];
  end

endmodule

// File: rtl/csr_row_streamer.sv
// Streams one CSR row of J (bias, length, then value/index beats).
// Define CSR_ROW_CHECK_EN to enable ROM-consistency checks and cfg_err.
module csr_row_streamer
    import csr_pkg::*;
#(
    parameter int NUM_PBITS   = CSR_NUM_PBITS,
    parameter int MAX_NNZ     = CSR_MAX_NNZ,
    parameter int VAL_WIDTH   = CSR_VAL_WIDTH,
    parameter int INDEX_WIDTH = $clog2(NUM_PBITS),
    parameter int H_WIDTH     = CSR_H_WIDTH,
    parameter int LEN_WIDTH   = CSR_LEN_WIDTH,
    parameter     PTR_FILE    = "",
    parameter     VAL_FILE    = "",
    parameter     IDX_FILE    = "",
    parameter     H_FILE      = ""
) (
    input logic               clk,
    input logic               reset_n,
    csr_row_streamer_if.slave bus
);
    localparam int ROW_W  = $clog2(NUM_PBITS + 1);
    localparam int PTR_W  = $clog2(MAX_NNZ + 1);
    localparam int NNZ_AW = $clog2(MAX_NNZ);
    localparam int HA_W   = $clog2(NUM_PBITS);
`ifdef CSR_ROW_CHECK_EN
    // One spare bit so corrupt indices are representable.
    localparam int IDXR_W = INDEX_WIDTH + 1;
`else
    localparam int IDXR_W = INDEX_WIDTH;
`endif
    localparam logic [ROW_W-1:0]     ROW_LIM = ROW_W'(NUM_PBITS);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = '1;

    csr_state_t state, state_nx;
    logic latch_row, latch_ptr, rd_issue;

    logic [ROW_W-1:0]       row_q, ptr_addr;
    logic                   row_ok, in_ok, bad_row;
    logic [PTR_W-1:0]       ptr_lo, ptr_rd, ptr_diff;
    logic [H_WIDTH-1:0]     h_rd, h_q;
    logic [LEN_WIDTH-1:0]   len_q, len_sat, len_new, k_q;
    logic [NNZ_AW-1:0]      nnz_addr;
    logic [VAL_WIDTH-1:0]   val_rd, val_q;
    logic [IDXR_W-1:0]      idx_rd;
    logic [INDEX_WIDTH-1:0] idx_q;
    logic                   idx_ok, rd_pend, dv_q, ld_q;

    assign in_ok  = bus.current_row < ROW_LIM;
    assign row_ok = row_q < ROW_LIM;

    // row_ptr is single-ported: lo is read while idle, hi in PTR.
    always_comb begin
        ptr_addr = '0;
        if (state == IDLE) begin
            if (in_ok) ptr_addr = bus.current_row;
        end else if (row_ok) begin
            ptr_addr = row_q + ROW_W'(1);
        end
    end

    assign ptr_diff = ptr_rd - ptr_lo;
    assign len_sat  = (ptr_diff > PTR_W'(LEN_MAX)) ?
                      LEN_MAX : ptr_diff[LEN_WIDTH-1:0];
`ifdef CSR_ROW_CHECK_EN
    assign bad_row = (ptr_rd < ptr_lo) ||
                     (ptr_rd > PTR_W'(MAX_NNZ));
    assign idx_ok  = idx_rd < IDXR_W'(NUM_PBITS);
`else
    assign bad_row = 1'b0;
    assign idx_ok  = 1'b1;
`endif
    assign len_new  = (!row_ok || bad_row) ? '0 : len_sat;
    assign nnz_addr = NNZ_AW'(ptr_lo + PTR_W'(k_q));

    csr_rom #(.WIDTH(PTR_W), .DEPTH(NUM_PBITS + 1),
              .INIT_FILE(PTR_FILE), .SYNC(1'b0))
    u_ptr (.clk(clk), .addr(ptr_addr), .data(ptr_rd));

    csr_rom #(.WIDTH(H_WIDTH), .DEPTH(NUM_PBITS),
              .INIT_FILE(H_FILE), .SYNC(1'b0))
    u_h (.clk(clk), .addr(row_q[HA_W-1:0]), .data(h_rd));

    csr_rom #(.WIDTH(VAL_WIDTH), .DEPTH(MAX_NNZ),
              .INIT_FILE(VAL_FILE), .SYNC(1'b1))
    u_val (.clk(clk), .addr(nnz_addr), .data(val_rd));

    csr_rom #(.WIDTH(IDXR_W), .DEPTH(MAX_NNZ),
              .INIT_FILE(IDX_FILE), .SYNC(1'b1))
    u_idx (.clk(clk), .addr(nnz_addr), .data(idx_rd));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (bus.start_load) state_nx = PTR;
            PTR:    state_nx = (len_new == '0) ? DRAIN : STREAM;
            STREAM: if (k_q == len_q - 1'b1) state_nx = DRAIN;
            DRAIN:  state_nx = DONE;
            DONE:   if (bus.compute_done && ld_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        latch_row = 1'b0;
        latch_ptr = 1'b0;
        rd_issue  = 1'b0;
        unique case (state)
            IDLE:    latch_row = bus.start_load;
            PTR:     latch_ptr = 1'b1;
            STREAM:  rd_issue  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_q   <= '0;
            ptr_lo  <= '0;
            h_q     <= '0;
            len_q   <= '0;
            k_q     <= '0;
            rd_pend <= 1'b0;
            dv_q    <= 1'b0;
            val_q   <= '0;
            idx_q   <= '0;
            ld_q    <= 1'b0;
        end else begin
            if (latch_row) begin
                row_q  <= bus.current_row;
                ptr_lo <= in_ok ? ptr_rd : '0;
            end
            if (latch_ptr) begin
                h_q   <= row_ok ? h_rd : '0;
                len_q <= len_new;
                k_q   <= '0;
            end else if (rd_issue) begin
                k_q <= k_q + 1'b1;
            end
            rd_pend <= rd_issue;
            dv_q    <= rd_pend && idx_ok;
            if (rd_pend && idx_ok) begin
                val_q <= val_rd;
                idx_q <= idx_rd[INDEX_WIDTH-1:0];
            end
            ld_q <= (state == DONE) && !(bus.compute_done && ld_q);
        end
    end

`ifdef CSR_ROW_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if ((latch_ptr && row_ok && bad_row) ||
                     (rd_pend && !idx_ok)) begin
            err_q <= 1'b1;
        end
    end
    assign bus.cfg_err = err_q;
`else
    assign bus.cfg_err = 1'b0;
`endif

    assign bus.data_valid = dv_q;
    assign bus.value      = val_q;
    assign bus.index      = idx_q;
    assign bus.row_length = len_q;
    assign bus.h          = h_q;
    assign bus.load_done  = ld_q;

endmodule

// File: tb/tb_csr_row_streamer.sv
// Randomised self-checking bench for csr_row_streamer against a
// row-level CSR reference model held in plain arrays.
module tb_csr_row_streamer;
    localparam int NP   = 16;
    localparam int MAXN = 256;
    localparam int LMAX = 31;
`ifdef CSR_ROW_CHECK_EN
    localparam int IDXR = 5;
`else
    localparam int IDXR = 4;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   errors  = 0;
    bit   exp_cfg = 1'b0;

    logic [8:0]      ptr [NP+1];
    logic [8:0]      hm  [NP];
    logic [7:0]      vm  [MAXN];
    logic [IDXR-1:0] im  [MAXN];
    int lens [NP] = '{2, 3, 3, 4, 0, 5, 1, 6, 2, 40, 3, 0, 7, 4, 2, 1};

    always #5 clk = ~clk;

    csr_row_streamer_if bus ();
    csr_row_streamer dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic load_roms();
        ptr[0] = '0;
        for (int i = 0; i < NP; i++) ptr[i+1] = ptr[i] + 9'(lens[i]);
        for (int i = 0; i < NP; i++) hm[i] = 9'($urandom);
        for (int i = 0; i < MAXN; i++) begin
            vm[i] = 8'($urandom);
            im[i] = IDXR'($urandom_range(0, NP - 1));
        end
        hm[2] = 9'h00C;
        vm[5] = 8'h08; vm[6] = 8'hF8; vm[7] = 8'h10;
        im[5] = IDXR'(0); im[6] = IDXR'(3); im[7] = IDXR'(7);
`ifdef CSR_ROW_CHECK_EN
        ptr[6] = 9'd10;
        ptr[7] = 9'd4;
        im[1]  = IDXR'(5'h1F);
`endif
        for (int i = 0; i <= NP; i++) dut.u_ptr.mem[i] = ptr[i];
        for (int i = 0; i < NP; i++) dut.u_h.mem[i] = hm[i];
        for (int i = 0; i < MAXN; i++) begin
            dut.u_val.mem[i] = vm[i];
            dut.u_idx.mem[i] = im[i];
        end
    endtask

    // Requests row r; optionally pokes start_load/compute_done at
    // offset pulse_n, and acknowledges cd_delay cycles after load_done.
    task automatic stream_row(input int r, input int pulse_n,
                              input int cd_delay);
        int lo, hi, el;
        logic [8:0] eh;
        logic [7:0] ev [LMAX];
        logic [IDXR-1:0] ei [LMAX];
        bit eok [LMAX];
        bit flag, edv, eld;
        el = 0;
        eh = '0;
        if (r < NP) begin
            lo = int'(ptr[r]);
            hi = int'(ptr[r+1]);
            eh = hm[r];
            flag = 1'b0;
`ifdef CSR_ROW_CHECK_EN
            flag = (hi < lo) || (hi > MAXN);
`endif
            if (flag) exp_cfg = 1'b1;
            else el = (hi - lo > LMAX) ? LMAX : hi - lo;
            for (int k = 0; k < el; k++) begin
                ev[k]  = vm[lo+k];
                ei[k]  = im[lo+k];
                eok[k] = int'(im[lo+k]) < NP;
                if (!eok[k]) exp_cfg = 1'b1;
            end
        end
        bus.current_row = 5'(r);
        bus.start_load  = 1'b1;
        @(negedge clk);
        bus.start_load = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (bus.h !== eh) begin
            errors++;
            $display("FAIL h row=%0d got=%h want=%h", r, bus.h, eh);
        end
        if (bus.row_length !== 5'(el)) begin
            errors++;
            $display("FAIL row_length row=%0d got=%0d want=%0d",
                     r, bus.row_length, el);
        end
        for (int n = 2; n <= 3 + el; n++) begin
            @(negedge clk);
            bus.start_load   = (n == pulse_n);
            bus.compute_done = (n == pulse_n);
            if (n == pulse_n) bus.current_row = 5'((r + 1) % NP);
            edv = 1'b0;
            if (n >= 3 && n <= 2 + el) edv = eok[n-3];
            eld = (n == 3 + el);
            vectors += 2;
            if (bus.data_valid !== edv) begin
                errors++;
                $display("FAIL data_valid row=%0d cyc=%0d got=%b want=%b",
                         r, n, bus.data_valid, edv);
            end
            if (bus.load_done !== eld) begin
                errors++;
                $display("FAIL load_done row=%0d cyc=%0d got=%b want=%b",
                         r, n, bus.load_done, eld);
            end
            if (edv) begin
                vectors += 2;
                if (bus.value !== ev[n-3]) begin
                    errors++;
                    $display("FAIL value row=%0d beat=%0d got=%h want=%h",
                             r, n - 3, bus.value, ev[n-3]);
                end
                if (bus.index !== ei[n-3][3:0]) begin
                    errors++;
                    $display("FAIL index row=%0d beat=%0d got=%h want=%h",
                             r, n - 3, bus.index, ei[n-3][3:0]);
                end
            end
        end
        for (int d = 0; d < cd_delay; d++) begin
            @(negedge clk);
            vectors++;
            if (bus.load_done !== 1'b1 || bus.data_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_hold row=%0d got ld=%b dv=%b want ld=1 dv=0",
                         r, bus.load_done, bus.data_valid);
            end
        end
        bus.compute_done = 1'b1;
        @(negedge clk);
        bus.compute_done = 1'b0;
        vectors += 4;
        if (bus.load_done !== 1'b0) begin
            errors++;
            $display("FAIL done_release row=%0d got=%b want=0",
                     r, bus.load_done);
        end
        if (bus.cfg_err !== exp_cfg) begin
            errors++;
            $display("FAIL cfg_err row=%0d got=%b want=%b",
                     r, bus.cfg_err, exp_cfg);
        end
        if (bus.h !== eh) begin
            errors++;
            $display("FAIL h_hold row=%0d got=%h want=%h", r, bus.h, eh);
        end
        if (bus.row_length !== 5'(el)) begin
            errors++;
            $display("FAIL len_hold row=%0d got=%0d want=%0d",
                     r, bus.row_length, el);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        load_roms();
        repeat (2) @(negedge clk);
        vectors += 7;
        if (bus.data_valid !== 1'b0 || bus.load_done !== 1'b0 ||
            bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got dv=%b ld=%b err=%b want 0",
                     bus.data_valid, bus.load_done, bus.cfg_err);
        end
        if (bus.value !== '0 || bus.index !== '0) begin
            errors++;
            $display("FAIL reset_beat got %h/%h want 0", bus.value, bus.index);
        end
        if (bus.h !== '0 || bus.row_length !== '0) begin
            errors++;
            $display("FAIL reset_row got %h/%h want 0", bus.h, bus.row_length);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_row2();
        stream_row(2, -1, 0);
    endtask

    task automatic test_zero_len();
        stream_row(4, -1, 3);
    endtask

    task automatic test_out_of_range();
        stream_row(16, -1, 0);
    endtask

    task automatic test_ignore_start();
        stream_row(7, 4, 1);
    endtask

    task automatic test_saturate();
        stream_row(9, -1, 1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < NP; r++) stream_row(r, -1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++)
            stream_row(int'($urandom_range(0, 31)), -1,
                       int'($urandom_range(0, 3)));
    endtask

    task automatic test_mid_reset();
        bus.current_row = 5'd3;
        bus.start_load  = 1'b1;
        @(negedge clk);
        bus.start_load = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.data_valid !== 1'b1) begin
            errors++;
            $display("FAIL beat2_valid got=%b want=1", bus.data_valid);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors += 3;
        if (bus.data_valid !== 1'b0 || bus.load_done !== 1'b0 ||
            bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL async_flags got dv=%b ld=%b err=%b want 0",
                     bus.data_valid, bus.load_done, bus.cfg_err);
        end
        if (bus.value !== '0 || bus.index !== '0) begin
            errors++;
            $display("FAIL async_beat got %h/%h want 0", bus.value, bus.index);
        end
        if (bus.h !== '0 || bus.row_length !== '0) begin
            errors++;
            $display("FAIL async_row got %h/%h want 0", bus.h, bus.row_length);
        end
        exp_cfg = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        stream_row(3, -1, 0);
    endtask

`ifdef CSR_ROW_CHECK_EN
    task automatic test_cfg();
        reset_n = 1'b0;
        exp_cfg = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        stream_row(6, -1, 0);
        reset_n = 1'b0;
        exp_cfg = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        stream_row(0, -1, 0);
    endtask
`endif

    initial begin
        bus.start_load   = 1'b0;
        bus.compute_done = 1'b0;
        bus.current_row  = '0;
        test_reset();
        test_row2();
        test_zero_len();
        test_out_of_range();
        test_ignore_start();
        test_saturate();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef CSR_ROW_CHECK_EN
        test_cfg();
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
